// File: rtl/i2c_reg_master_pkg.sv
// Shared constants for the I2C register master: FSM encodings, quarter indices,
// symbol commands, bus bit values and the latched request layout.
package i2c_reg_master_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_BIT    = 3'd2;
  localparam logic [2:0] ST_ACK    = 3'd3;
  localparam logic [2:0] ST_RSTART = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic [1:0] SYM_START  = 2'd0;
  localparam logic [1:0] SYM_BIT    = 2'd1;
  localparam logic [1:0] SYM_RSTART = 2'd2;
  localparam logic [1:0] SYM_STOP   = 2'd3;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;
  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;

  typedef struct packed {
    logic       rw;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
  } req_t;

  // Byte 3 only exists on reads, where the master releases SDA for the target.
  function automatic logic [7:0] tx_byte(input req_t r, input logic [1:0] idx);
    case (idx)
      2'd0:    return {r.dev_addr, RW_WRITE};
      2'd1:    return r.reg_addr;
      2'd2:    return (r.rw == RW_READ) ? {r.dev_addr, RW_READ} : r.wdata;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/i2c_master_bit.sv
// Quarter-bit sequencer for one bus symbol (START, BIT, RSTART, STOP),
// including the SCL stretch wait in q2 and the bus-free check in START q1.
module i2c_master_bit
  import i2c_reg_master_pkg::*;
#(
  parameter int QUARTER_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       active,
  input  logic [1:0] sym,
  input  logic       tx_bit,
  input  logic       sda_in,
  input  logic       scl_in,
  output logic       sda_out,
  output logic       scl_out,
  output logic       rx_bit,
  output logic       sym_done,
  output logic       bus_err
);

  localparam int TW = (QUARTER_TICKS > 1) ? $clog2(QUARTER_TICKS) : 1;

  logic [TW-1:0] tick_cnt;
  logic [1:0]    quarter;
  logic          tick;
  logic          stall;

  assign tick     = active && ce && (tick_cnt == TW'(QUARTER_TICKS - 1));
  assign stall    = (quarter == Q2) && !scl_in && (sym != SYM_START);
  assign bus_err  = tick && (sym == SYM_START) && (quarter == Q1) && !(sda_in && scl_in);
  assign sym_done = tick && !stall && ((quarter == Q3) || bus_err);

  // A bus-busy abort leaves both lines untouched so nothing is ever driven.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      quarter  <= Q0;
      sda_out  <= 1'b1;
      scl_out  <= 1'b1;
      rx_bit   <= 1'b1;
    end else if (!active) begin
      tick_cnt <= '0;
      quarter  <= Q0;
    end else if (ce) begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      if (tick && !stall) begin
        quarter <= bus_err ? Q0 : quarter + 2'd1;
        case (sym)
          SYM_START: begin
            case (quarter)
              Q0:      begin sda_out <= 1'b1; scl_out <= 1'b1; end
              Q2:      sda_out <= 1'b0;
              Q3:      scl_out <= 1'b0;
              default: ;
            endcase
          end
          SYM_BIT: begin
            case (quarter)
              Q0:      begin scl_out <= 1'b0; sda_out <= tx_bit; end
              Q1:      scl_out <= 1'b1;
              Q2:      rx_bit <= sda_in;
              default: scl_out <= 1'b0;
            endcase
          end
          SYM_RSTART: begin
            case (quarter)
              Q0:      sda_out <= 1'b1;
              Q1:      scl_out <= 1'b1;
              Q2:      sda_out <= 1'b0;
              default: scl_out <= 1'b0;
            endcase
          end
          default: begin
            case (quarter)
              Q0:      sda_out <= 1'b0;
              Q1:      scl_out <= 1'b1;
              Q3:      sda_out <= 1'b1;
              default: ;
            endcase
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/i2c_reg_master.sv
// Single-master I2C initiator: one 8-bit register write or read on a 7-bit
// target, sequenced as bus symbols executed by i2c_master_bit.
module i2c_reg_master
  import i2c_reg_master_pkg::*;
#(
  parameter int QUARTER_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic [7:0] rdata,
  input  logic       sda_in,
  input  logic       scl_in,
  output logic       sda_out,
  output logic       scl_out
);

  logic [2:0] state;
  req_t       req;
  logic [2:0] bit_cnt;
  logic [1:0] byte_idx;
  logic [7:0] rx_shift;
  logic [7:0] cur_byte;
  logic [1:0] sym;
  logic       sym_active;
  logic       sym_done;
  logic       bus_err;
  logic       rx_bit;
  logic       tx_bit;
  logic       last_byte;

  always_comb begin
    sym        = SYM_BIT;
    sym_active = 1'b1;
    case (state)
      ST_START:      sym = SYM_START;
      ST_RSTART:     sym = SYM_RSTART;
      ST_STOP:       sym = SYM_STOP;
      ST_BIT, ST_ACK: sym = SYM_BIT;
      default:       sym_active = 1'b0;
    endcase
  end

  // The ACK slot is always released by the master; on the read byte that
  // release is the final master NACK.
  assign cur_byte  = tx_byte(req, byte_idx);
  assign tx_bit    = (state == ST_ACK) ? NACK : cur_byte[bit_cnt];
  assign last_byte = (req.rw == RW_READ) ? (byte_idx == 2'd3) : (byte_idx == 2'd2);

  i2c_master_bit #(
    .QUARTER_TICKS(QUARTER_TICKS)
  ) u_bit (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .active   (sym_active),
    .sym      (sym),
    .tx_bit   (tx_bit),
    .sda_in   (sda_in),
    .scl_in   (scl_in),
    .sda_out  (sda_out),
    .scl_out  (scl_out),
    .rx_bit   (rx_bit),
    .sym_done (sym_done),
    .bus_err  (bus_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      req      <= '0;
      bit_cnt  <= 3'd7;
      byte_idx <= 2'd0;
      rx_shift <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
      nack     <= 1'b0;
      rdata    <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            req      <= {rw, dev_addr, reg_addr, wdata};
            bit_cnt  <= 3'd7;
            byte_idx <= 2'd0;
            busy     <= 1'b1;
            nack     <= 1'b0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (sym_done) begin
            if (bus_err) begin
              nack  <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_BIT;
            end
          end
        end
        ST_BIT: begin
          if (sym_done) begin
            if (byte_idx == 2'd3) rx_shift <= {rx_shift[6:0], rx_bit};
            if (bit_cnt == 3'd0) state <= ST_ACK;
            else bit_cnt <= bit_cnt - 3'd1;
          end
        end
        ST_ACK: begin
          if (sym_done) begin
            bit_cnt <= 3'd7;
            if (byte_idx != 2'd3 && rx_bit != ACK) begin
              nack  <= 1'b1;
              state <= ST_STOP;
            end else if (last_byte) begin
              state <= ST_STOP;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              state    <= (req.rw == RW_READ && byte_idx == 2'd1) ? ST_RSTART : ST_BIT;
            end
          end
        end
        ST_RSTART: if (sym_done) state <= ST_BIT;
        ST_STOP:   if (sym_done) state <= ST_DONE;
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
          if (req.rw == RW_READ && !nack) rdata <= rx_shift;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
